// File: rtl/timer_array_if.sv
// Bus slave interface for timer_array: word-addressed read/write port with
// byte enables and a combinational read-data return.
interface timer_array_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] data_wr;
    logic [3:0]  mask;
    logic [31:0] data_rd;
    logic [31:0] data_rd_2;
    logic        stall;

    modport master (
        output address, read, write, data_wr, mask,
        input  data_rd, data_rd_2, stall
    );

    modport slave (
        input  address, read, write, data_wr, mask,
        output data_rd, data_rd_2, stall
    );
endinterface

// File: rtl/timer_array.sv
// timer_array: CHANNELS independent up-counters with compare match,
// auto-reload or one-shot mode, per-channel maskable interrupts ORed onto
// interrupt[IRQ_LINE], and an optional shared prescaler.
// Optional feature macro: TIMER_PRESCALER_EN (shared prescaler and PRESCALE
// register). Without it every cycle is a tick and PRESCALE reads 0.
// Register map, channel c: word 4c+0 COUNT, 4c+1 COMPARE, 4c+2 CTRL
// (bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN), 4c+3 STATUS (bit0 PENDING, W1C);
// word 4*CHANNELS PRESCALE.
module timer_array #(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int IRQ_LINE      = 3
) (
    input  logic          clk,
    input  logic          rst,
    timer_array_if.slave  bus,
    output logic [5:0]    interrupt
);

    localparam logic [5:0] PRESCALE_IDX = 6'(4 * CHANNELS);
    localparam logic [1:0] REG_COUNT    = 2'd0;
    localparam logic [1:0] REG_COMPARE  = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;

    logic [5:0] word_idx;
    logic [3:0] chan_sel;
    logic [1:0] reg_sel;
    logic       in_chan;

    assign word_idx = bus.address[7:2];
    assign chan_sel = word_idx[5:2];
    assign reg_sel  = word_idx[1:0];
    assign in_chan  = (word_idx < PRESCALE_IDX);

    // Upper and byte-offset address bits are decoded upstream.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.address[31:8], bus.address[1:0]};

    logic [COUNTER_WIDTH-1:0] count_q   [CHANNELS];
    logic [COUNTER_WIDTH-1:0] count_d   [CHANNELS];
    logic [COUNTER_WIDTH-1:0] compare_q [CHANNELS];
    logic [COUNTER_WIDTH-1:0] compare_d [CHANNELS];
    logic [CHANNELS-1:0]      en_q, en_d, auto_q, auto_d;
    logic [CHANNELS-1:0]      irq_en_q, irq_en_d, pending_q, pending_d;
    logic [CHANNELS-1:0]      match;
    logic                     irq_q, irq_d;
    logic                     tick;
    logic [31:0]              chan_wdata;

    // Byte-enable merge of write data onto an existing 32-bit value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

`ifdef TIMER_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic [31:0] pre_wdata;
    logic        prescale_wr;

    assign prescale_wr = bus.write && (word_idx == PRESCALE_IDX);

    // Prescaler: tick when pcnt reaches PRESCALE; a PRESCALE write restarts it and eats the tick.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q + 16'd1;
        tick       = 1'b0;
        pre_wdata  = '0;
        if (prescale_wr) begin
            pre_wdata  = merge_bytes({16'h0, prescale_q}, bus.data_wr, bus.mask);
            prescale_d = pre_wdata[15:0];
            pcnt_d     = '0;
        end else if (pcnt_q == prescale_q) begin
            tick   = 1'b1;
            pcnt_d = '0;
        end
    end

    // Prescaler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Compare match per channel, only counted on an enabled tick.
    always_comb begin
        match = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            match[c] = tick && en_q[c] && (count_q[c] == compare_q[c]);
        end
    end

    // Channel next state: tick behaviour first, then bus writes override it.
    always_comb begin
        chan_wdata = '0;
        irq_d      = |(pending_q & irq_en_q);
        for (int c = 0; c < CHANNELS; c++) begin
            count_d[c]   = count_q[c];
            compare_d[c] = compare_q[c];
            en_d[c]      = en_q[c];
            auto_d[c]    = auto_q[c];
            irq_en_d[c]  = irq_en_q[c];
            pending_d[c] = pending_q[c] | match[c];
            if (tick && en_q[c]) begin
                if (match[c]) begin
                    if (auto_q[c]) count_d[c] = '0;
                    else           en_d[c]    = 1'b0;
                end else begin
                    count_d[c] = count_q[c] + COUNTER_WIDTH'(1);
                end
            end
            if (bus.write && in_chan && (chan_sel == 4'(c))) begin
                case (reg_sel)
                    REG_COUNT: begin
                        chan_wdata = merge_bytes(32'(count_q[c]), bus.data_wr, bus.mask);
                        count_d[c] = chan_wdata[COUNTER_WIDTH-1:0];
                    end
                    REG_COMPARE: begin
                        chan_wdata   = merge_bytes(32'(compare_q[c]), bus.data_wr, bus.mask);
                        compare_d[c] = chan_wdata[COUNTER_WIDTH-1:0];
                    end
                    REG_CTRL: begin
                        if (bus.mask[0]) begin
                            en_d[c]     = bus.data_wr[0];
                            auto_d[c]   = bus.data_wr[1];
                            irq_en_d[c] = bus.data_wr[2];
                        end
                    end
                    REG_STATUS: begin
                        // A match on the same edge wins over the clear.
                        if (bus.mask[0] && bus.data_wr[0]) pending_d[c] = match[c];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Channel and interrupt state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the per-channel arrays are flip-flops, not RAM, so every entry is reset explicitly.
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= '0;
                compare_q[c] <= '0;
            end
            en_q      <= '0;
            auto_q    <= '0;
            irq_en_q  <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= count_d[c];
                compare_q[c] <= compare_d[c];
            end
            en_q      <= en_d;
            auto_q    <= auto_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    // Read mux: combinational view of current state while read is high.
    always_comb begin
        bus.data_rd = '0;
        if (bus.read) begin
            if (in_chan) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (chan_sel == 4'(c)) begin
                        case (reg_sel)
                            REG_COUNT:   bus.data_rd = 32'(count_q[c]);
                            REG_COMPARE: bus.data_rd = 32'(compare_q[c]);
                            REG_CTRL:    bus.data_rd = {29'h0, irq_en_q[c], auto_q[c], en_q[c]};
                            REG_STATUS:  bus.data_rd = {31'h0, pending_q[c]};
                            default:     bus.data_rd = '0;
                        endcase
                    end
                end
            end
`ifdef TIMER_PRESCALER_EN
            else if (word_idx == PRESCALE_IDX) begin
                bus.data_rd = {16'h0, prescale_q};
            end
`endif
        end
    end

    // Interrupt output: only IRQ_LINE is driven.
    always_comb begin
        interrupt           = '0;
        interrupt[IRQ_LINE] = irq_q;
    end

    assign bus.data_rd_2 = '0;
    assign bus.stall     = 1'b0;

endmodule

// File: tb/tb_timer_array.sv
// Testbench for timer_array: directed sequences followed by random bus
// traffic, checked by a scoreboard against a behavioural register model.
module tb_timer_array;

    localparam int CH       = 4;
    localparam int CW       = 32;
    localparam int IRQ_LINE = 3;
    localparam int PRE_IDX  = 4 * CH;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [5:0]  irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] interrupt;

    timer_array_if bus();

    timer_array #(
        .CHANNELS      (CH),
        .COUNTER_WIDTH (CW),
        .IRQ_LINE      (IRQ_LINE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    // Behavioural model of the register file.
    logic [31:0] m_count [CH];
    logic [31:0] m_cmp   [CH];
    bit          m_en    [CH];
    bit          m_auto  [CH];
    bit          m_ie    [CH];
    bit          m_pend  [CH];
    logic [15:0] m_pre;
    logic [15:0] m_pcnt;
    bit          m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_count[c] = '0; m_cmp[c] = '0;
            m_en[c] = 0; m_auto[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
        end
        m_pre = '0; m_pcnt = '0; m_irq = 0;
    endtask

    function automatic logic [31:0] model_read(input int idx);
        int c;
        c = idx / 4;
        if (idx < PRE_IDX) begin
            case (idx % 4)
                0: return m_count[c];
                1: return m_cmp[c];
                2: return {29'h0, m_ie[c], m_auto[c], m_en[c]};
                default: return {31'h0, m_pend[c]};
            endcase
        end
`ifdef TIMER_PRESCALER_EN
        if (idx == PRE_IDX) return {16'h0, m_pre};
`endif
        return 32'h0;
    endfunction

    // One clock edge of the model: tick behaviour, then the bus write.
    task automatic model_step(input bit wr, input int idx, input logic [31:0] data, input logic [3:0] be);
        bit          tick;
        bit          hit      [CH];
        logic [31:0] old_cnt  [CH];
        bit          irq_next;
        logic [31:0] tmp;
        int          c;
`ifdef TIMER_PRESCALER_EN
        if (wr && idx == PRE_IDX) begin
            tmp = apply_mask({16'h0, m_pre}, data, be);
            m_pre = tmp[15:0];
            m_pcnt = '0;
            tick = 0;
        end else if (m_pcnt == m_pre) begin
            tick = 1;
            m_pcnt = '0;
        end else begin
            tick = 0;
            m_pcnt = m_pcnt + 16'd1;
        end
`else
        tick = 1;
`endif
        irq_next = 0;
        for (int k = 0; k < CH; k++) if (m_pend[k] && m_ie[k]) irq_next = 1;
        for (int k = 0; k < CH; k++) begin
            old_cnt[k] = m_count[k];
            hit[k] = tick && m_en[k] && (m_count[k] == m_cmp[k]);
            if (tick && m_en[k]) begin
                if (hit[k]) begin
                    m_pend[k] = 1;
                    if (m_auto[k]) m_count[k] = '0;
                    else           m_en[k] = 0;
                end else begin
                    m_count[k] = m_count[k] + 32'd1;
                end
            end
        end
        if (wr && idx < PRE_IDX) begin
            c = idx / 4;
            case (idx % 4)
                0: m_count[c] = apply_mask(old_cnt[c], data, be);
                1: m_cmp[c]   = apply_mask(m_cmp[c], data, be);
                2: if (be[0]) {m_ie[c], m_auto[c], m_en[c]} = data[2:0];
                default: if (be[0] && data[0]) m_pend[c] = hit[c];
            endcase
        end
        m_irq = irq_next;
    endtask

    // One bus cycle, entered and left at posedge+1.
    task automatic cycle(input bit rd, input bit wr, input int idx,
                         input logic [31:0] data, input logic [3:0] be, input string name);
        logic [5:0] e_irq;
        bus.address = 32'(idx) << 2;
        bus.read    = rd;
        bus.write   = wr;
        bus.data_wr = data;
        bus.mask    = be;
        if (rd) begin
            e_irq = '0;
            e_irq[IRQ_LINE] = m_irq;
            sb.push_back('{name, model_read(idx), e_irq});
        end
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(wr, idx, data, be);
        #1;
    endtask

    task automatic rd(input int idx, input string name);
        cycle(1'b1, 1'b0, idx, 32'h0, 4'h0, name);
    endtask

    task automatic wr(input int idx, input logic [31:0] data, input logic [3:0] be);
        cycle(1'b0, 1'b1, idx, data, be, "");
    endtask

    // Monitor: whenever a read is presented, pop and compare.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.read === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: read seen with data 0x%08h, expected an entry", bus.data_rd);
            end else begin
                e = sb.pop_front();
                check({e.name, "/data_rd"}, bus.data_rd, e.data);
                check({e.name, "/interrupt"}, 32'(interrupt), 32'(e.irq));
                check("tied_outputs", bus.data_rd_2 | 32'(bus.stall), 32'h0);
            end
        end else if (bus.read === 1'b0) begin
            check("data_rd_idle", bus.data_rd, 32'h0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          idx;
        logic [31:0] data;
        logic [3:0]  be;
        rst = 1'b1;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
        bus.data_wr = '0; bus.mask = '0;
        model_reset();
        @(posedge clk); #1;

        // Reset state.
        for (int i = 0; i <= PRE_IDX; i++) rd(i, "reset_state");
        rst = 1'b0;
        rd(20, "unmapped_after_reset");

        // Auto-reload, channel 0.
        wr(PRE_IDX, 32'h0, 4'hF);
        wr(1, 32'd3, 4'hF);
        wr(2, 32'd7, 4'h1);
        repeat (10) rd(0, "autoreload_count");
        rd(3, "autoreload_status");
        cycle(1'b1, 1'b1, 3, 32'h1, 4'h1, "status_clear_same_cycle");
        rd(3, "status_after_clear");

        // Status clear colliding with a match.
        repeat (8) cycle(1'b1, 1'b1, 3, 32'h1, 4'h1, "status_clear_collision");

        // COUNT write on a tick edge.
        wr(0, 32'h10, 4'hF);
        rd(0, "count_write_on_tick");
        rd(0, "count_after_write");
        wr(2, 32'h0, 4'h1);

        // One-shot with prescaler, channel 1.
        wr(PRE_IDX, 32'd2, 4'hF);
        wr(5, 32'd1, 4'hF);
        wr(6, 32'd5, 4'h1);
        repeat (10) rd(4, "oneshot_count");
        rd(6, "oneshot_ctrl");
        rd(7, "oneshot_status");
        rd(PRE_IDX, "prescale_read");

        // Wrap, channel 2.
        wr(PRE_IDX, 32'h0, 4'hF);
        wr(9, 32'h1, 4'hF);
        wr(8, 32'hFFFF_FFFE, 4'hF);
        wr(10, 32'h3, 4'h1);
        repeat (6) rd(8, "wrap_count");
        rd(11, "wrap_status");

        // Masked write and unmapped accesses.
        wr(13, 32'h1122_3344, 4'hF);
        wr(13, 32'hAABB_CCDD, 4'b0101);
        rd(13, "masked_compare");
        wr(40, 32'hFFFF_FFFF, 4'hF);
        rd(17, "unmapped_17");
        rd(40, "unmapped_40");
        rd(63, "unmapped_63");

        // Reset mid-run while the interrupt is asserted.
        rd(7, "pre_reset_status");
        rst = 1'b1;
        model_reset();
        for (int i = 0; i <= PRE_IDX; i++) rd(i, "midrun_reset");
        rst = 1'b0;

        // Random traffic.
        repeat (500) begin
            idx = ($urandom % 8 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, PRE_IDX));
            if (idx < PRE_IDX) begin
                case (idx % 4)
                    0, 1:    data = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 9);
                    2:       data = $urandom_range(0, 7);
                    default: data = $urandom_range(0, 1);
                endcase
            end else if (idx == PRE_IDX) begin
                data = $urandom_range(0, 3);
            end else begin
                data = $urandom;
            end
            be = ($urandom % 2 == 0) ? 4'hF : 4'($urandom);
            cycle(($urandom % 3) != 0, ($urandom % 3) == 0, idx, data, be, "random");
        end

        bus.read  = 1'b0;
        bus.write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
